// File: rtl/roi_seq_pkg.sv
// Shared definitions for the ROI scan sequencer.
//   roi_seq_state_t : sequencer FSM states (idle, running a scan, done pulse)
//   roi_seq_cnt_w() : width of the phase counter for given shift-register lengths
package roi_seq_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } roi_seq_state_t;

   function automatic int unsigned roi_seq_cnt_w(input int unsigned din_n,
                                                 input int unsigned dout_n);
      return $clog2(2 * din_n + dout_n + 1);
   endfunction

endpackage

// File: rtl/roi_seq_sdo_sync.sv
// Two-flop synchronizer for the harness serial output when it comes back through a pad.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : raw serial input
//   q     : input delayed by two clock cycles
module roi_seq_sdo_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/roi_scan_seq.sv
// Serial scan sequencer for the ROI test harness. Shifts a parallel stimulus into the harness,
// strobes it into the ROI input register, waits DIN_N cycles, strobes the ROI result into the
// output shift register and shifts DOUT_N result bits back in.
// Optional feature macro: ROI_SEQ_SDO_SYNC_EN (adds a 2-flop synchronizer on sdo, which moves
// the sample window and done two cycles later).
// Ports:
//   clk     : single clock, shared with the harness
//   rst_n   : asynchronous active-low reset
//   start   : request, accepted only in idle
//   vec_in  : stimulus vector, sampled on the accepting edge
//   busy    : high from the accept edge until done
//   done    : one-cycle pulse, vec_out valid from this cycle on
//   vec_out : captured ROI result, held until the next done
//   sdi     : harness di
//   stb     : harness stb
//   sdo     : harness do
module roi_scan_seq
   import roi_seq_pkg::*;
#(
   parameter int unsigned DIN_N  = 256,
   parameter int unsigned DOUT_N = 256,
   parameter int unsigned CNT_W  = roi_seq_cnt_w(DIN_N, DOUT_N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIN_N-1:0]  vec_in,
   output logic              busy,
   output logic              done,
   output logic [DOUT_N-1:0] vec_out,
   output logic              sdi,
   output logic              stb,
   input  logic              sdo
);

   logic sdo_smp;

`ifdef ROI_SEQ_SDO_SYNC_EN
   localparam int unsigned Lat = 2;

   roi_seq_sdo_sync u_sdo_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sdo),
      .q     (sdo_smp)
   );
`else
   localparam int unsigned Lat = 0;

   assign sdo_smp = sdo;
`endif

   // Last RUN cycle index; widen the counter if the synchronizer latency pushes past CNT_W.
   localparam int unsigned LastC = 2 * DIN_N + DOUT_N + Lat;
   localparam int unsigned MinW  = $clog2(LastC + 1);
   localparam int unsigned CntW  = (CNT_W > MinW) ? CNT_W : MinW;

   // stb is registered, so it is requested one cycle before the strobe cycle.
   localparam logic [CntW-1:0] StbLoadPre = CntW'(DIN_N - 1);
   localparam logic [CntW-1:0] StbCapPre  = CntW'(2 * DIN_N - 1);
   localparam logic [CntW-1:0] SmpFirst   = CntW'(2 * DIN_N + 1 + Lat);
   localparam logic [CntW-1:0] SmpLast    = CntW'(LastC);

   roi_seq_state_t    state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DIN_N-1:0]  rot_q, rot_d;
   logic [DOUT_N-1:0] cap_q, cap_d;
   logic [DOUT_N-1:0] vec_out_d;
   logic              sdi_d, stb_d, busy_d, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rot_q   <= '0;
         cap_q   <= '0;
         vec_out <= '0;
         sdi     <= 1'b0;
         stb     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rot_q   <= rot_d;
         cap_q   <= cap_d;
         vec_out <= vec_out_d;
         sdi     <= sdi_d;
         stb     <= stb_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rot_d     = rot_q;
      cap_d     = cap_q;
      vec_out_d = vec_out;
      sdi_d     = 1'b0;
      stb_d     = 1'b0;
      busy_d    = busy;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cnt_d   = '0;
               // sdi is registered: present the MSB now and keep rot one step ahead.
               sdi_d   = vec_in[DIN_N-1];
               rot_d   = {vec_in[DIN_N-2:0], vec_in[DIN_N-1]};
               busy_d  = 1'b1;
            end
         end
         StRun: begin
            cnt_d = cnt_q + 1'b1;
            sdi_d = rot_q[DIN_N-1];
            rot_d = {rot_q[DIN_N-2:0], rot_q[DIN_N-1]};
            stb_d = (cnt_q == StbLoadPre) || (cnt_q == StbCapPre);
            if (cnt_q >= SmpFirst) begin
               cap_d = {cap_q[DOUT_N-2:0], sdo_smp};
            end
            if (cnt_q == SmpLast) begin
               state_d   = StDone;
               cnt_d     = '0;
               sdi_d     = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               vec_out_d = {cap_q[DOUT_N-2:0], sdo_smp};
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

endmodule
